// File: rtl/ppu_line_writer_pkg.sv
// Shared PPU definitions: coordinate/pixel widths and the RGB555 palette entry format.
// Used by both the background layer and the line writer.
package ppu_line_writer_pkg;

  localparam int unsigned PPU_W_COORD     = 12;
  localparam int unsigned PPU_W_RGB       = 15;
  localparam int unsigned PPU_W_PAL_INDEX = 8;
  localparam int unsigned PPU_W_PIXDATA   = PPU_W_RGB;

  // Palette entry / line buffer pixel, blue in the top bits.
  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } rgb555_t;

endpackage

// File: rtl/ppu_line_writer.sv
// Background pixel stream consumer: resolves paletted pixels through an external
// synchronous palette RAM, applies index-0 transparency and writes RGB555 into the line buffer.
module ppu_line_writer
  import ppu_line_writer_pkg::*;
#(
  parameter int unsigned W_COORD     = PPU_W_COORD,
  parameter int unsigned W_PIXDATA   = PPU_W_PIXDATA,
  parameter int unsigned W_PAL_INDEX = PPU_W_PAL_INDEX
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   flush,
  input  logic [W_COORD-1:0]     cfg_start_x,
  input  logic [W_COORD-1:0]     cfg_line_len,
  input  logic                   cfg_transparency,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [W_PIXDATA-1:0]   in_pixdata,
  input  logic                   in_paletted,
  output logic                   pal_ren,
  output logic [W_PAL_INDEX-1:0] pal_addr,
  input  logic [PPU_W_RGB-1:0]   pal_rdata,
  output logic                   lbuf_wen,
  output logic [W_COORD-1:0]     lbuf_waddr,
  output logic [PPU_W_RGB-1:0]   lbuf_wdata,
  output logic                   line_done
);

  logic [W_COORD-1:0]     x;
  logic [W_COORD-1:0]     remaining;
  logic                   s2_vld;
  logic                   s2_pal;
  logic                   s2_transp;
  logic [W_COORD-1:0]     s2_x;
  rgb555_t                s2_direct;

  logic                   accept;
  logic [W_PAL_INDEX-1:0] index;
  logic                   transp_c;

  // Ready never looks at in_vld, so the upstream layer can rely on it combinationally.
  assign in_rdy   = en && !flush && (remaining != '0);
  assign accept   = in_vld && in_rdy;
  assign index    = in_pixdata[W_PAL_INDEX-1:0];
  assign transp_c = cfg_transparency && in_paletted && (index == '0);

  // Palette lookup issued in the accept cycle; data returns alongside the stage-2 write.
  assign pal_ren  = accept && in_paletted;
  assign pal_addr = pal_ren ? index : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x         <= '0;
      remaining <= '0;
      s2_vld    <= 1'b0;
      s2_pal    <= 1'b0;
      s2_transp <= 1'b0;
      s2_x      <= '0;
      s2_direct <= '0;
    end else begin
      s2_vld <= accept && !flush;
      if (flush) begin
        x         <= cfg_start_x;
        remaining <= cfg_line_len;
      end else if (accept) begin
        x         <= x + W_COORD'(1);
        remaining <= remaining - W_COORD'(1);
      end
      if (accept) begin
        s2_x      <= x;
        s2_pal    <= in_paletted;
        s2_transp <= transp_c;
        s2_direct <= rgb555_t'(in_pixdata[PPU_W_RGB-1:0]);
      end
    end
  end

  // Transparent pixels still consume their x slot, they just never strobe the buffer.
  assign lbuf_wen   = s2_vld && !s2_transp;
  assign lbuf_waddr = s2_x;
  assign lbuf_wdata = s2_pal ? pal_rdata : s2_direct;
  assign line_done  = (remaining == '0) && !s2_vld;

endmodule

// File: tb/tb_ppu_line_writer.sv
// Bench for ppu_line_writer: table of line scenarios plus hand-built enable-gap and reset sequences,
// with a cycle model feeding an expected-write queue checked at every negedge.
module tb_ppu_line_writer;
  import ppu_line_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [11:0] cfg_start_x;
  logic [11:0] cfg_line_len;
  logic        cfg_transparency;
  logic        in_vld;
  logic        in_rdy;
  logic [14:0] in_pixdata;
  logic        in_paletted;
  logic        pal_ren;
  logic [7:0]  pal_addr;
  logic [14:0] pal_rdata = 15'h0;
  logic        lbuf_wen;
  logic [11:0] lbuf_waddr;
  logic [14:0] lbuf_wdata;
  logic        line_done;

  ppu_line_writer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .cfg_start_x(cfg_start_x), .cfg_line_len(cfg_line_len), .cfg_transparency(cfg_transparency),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_pixdata(in_pixdata), .in_paletted(in_paletted),
    .pal_ren(pal_ren), .pal_addr(pal_addr), .pal_rdata(pal_rdata),
    .lbuf_wen(lbuf_wen), .lbuf_waddr(lbuf_waddr), .lbuf_wdata(lbuf_wdata), .line_done(line_done)
  );

  always #5 clk = ~clk;

  logic [14:0] pal_mem [256];
  always @(posedge clk) if (pal_ren) pal_rdata <= pal_mem[pal_addr];

  typedef struct packed {
    logic [11:0] addr;
    logic [14:0] data;
    logic        transp;
  } exp_t;

  typedef struct packed {
    logic [11:0]      start_x;
    logic [11:0]      len;
    logic             transp;
    logic [3:0][14:0] pix;
    logic [3:0]       pal;
    int               exp_writes;
    logic [11:0]      exp_first;
    logic [11:0]      exp_last;
  } vec_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [11:0] m_x = 12'd0;
  logic [11:0] m_rem = 12'd0;
  int          wr_count = 0;
  int          acc_count = 0;
  int          rdy_count = 0;
  logic [11:0] first_addr = 12'd0;
  logic [11:0] last_addr = 12'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: check this cycle's outputs, then advance the model across the coming edge.
  always @(negedge clk) begin : mon
    logic exp_rdy;
    logic acc;
    logic exp_wen;
    exp_t e;
    exp_rdy = en && !flush && (m_rem != 12'd0);
    acc     = in_vld && exp_rdy;
    chk("in_rdy", 32'(in_rdy), 32'(exp_rdy));
    chk("pal_ren", 32'(pal_ren), 32'(acc && in_paletted));
    if (acc && in_paletted) chk("pal_addr", 32'(pal_addr), 32'(in_pixdata[7:0]));
    chk("line_done", 32'(line_done), 32'((m_rem == 12'd0) && (q.size() == 0)));
    e = '0;
    exp_wen = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      exp_wen = !e.transp;
    end
    chk("lbuf_wen", 32'(lbuf_wen), 32'(exp_wen));
    if (exp_wen) begin
      chk("lbuf_waddr", 32'(lbuf_waddr), 32'(e.addr));
      chk("lbuf_wdata", 32'(lbuf_wdata), 32'(e.data));
    end
    if (lbuf_wen === 1'b1) begin
      if (wr_count == 0) first_addr = lbuf_waddr;
      last_addr = lbuf_waddr;
      wr_count++;
    end
    if (in_rdy === 1'b1) rdy_count++;
    if (!rst_n) begin
      m_x   = 12'd0;
      m_rem = 12'd0;
    end else if (flush) begin
      m_x   = cfg_start_x;
      m_rem = cfg_line_len;
    end else if (acc) begin
      e.addr   = m_x;
      e.transp = cfg_transparency && in_paletted && (in_pixdata[7:0] == 8'd0);
      e.data   = in_paletted ? pal_mem[in_pixdata[7:0]] : in_pixdata;
      q.push_back(e);
      m_x   = m_x + 12'd1;
      m_rem = m_rem - 12'd1;
      acc_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    wr_count  = 0;
    acc_count = 0;
    rdy_count = 0;
  endtask

  // Flush with in_vld high in the same cycle: that pixel must not be taken.
  task automatic do_flush(input logic [11:0] sx, input logic [11:0] len, input logic tr);
    cfg_start_x      = sx;
    cfg_line_len     = len;
    cfg_transparency = tr;
    en          = 1'b1;
    flush       = 1'b1;
    in_vld      = 1'b1;
    in_pixdata  = 15'h7FFF;
    in_paletted = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (line_done === 1'b1) seen = 1'b1;
    end
    tick();
    if (!seen) chk("line_done_timeout", 32'(0), 32'(1));
  endtask

  function automatic vec_t mk(input logic [11:0] sx, input logic [11:0] len, input logic tr,
                              input logic [14:0] p0, input logic [14:0] p1,
                              input logic [14:0] p2, input logic [14:0] p3,
                              input logic [3:0] pal, input int ew,
                              input logic [11:0] ef, input logic [11:0] el);
    vec_t v;
    v.start_x = sx;  v.len = len;  v.transp = tr;
    v.pix = {p3, p2, p1, p0};
    v.pal = pal;  v.exp_writes = ew;  v.exp_first = ef;  v.exp_last = el;
    return v;
  endfunction

  task automatic run_line(input vec_t v, input int id);
    int  i;
    int  guard;
    logic a;
    clear_stats();
    do_flush(v.start_x, v.len, v.transp);
    i = 0;
    guard = 0;
    if (v.len == 12'd0) begin
      for (int c = 0; c < 4; c++) tick();
    end else begin
      while (i < int'(v.len) && guard < 40) begin
        in_vld      = 1'b1;
        in_pixdata  = v.pix[i];
        in_paletted = v.pal[i];
        @(negedge clk);
        a = in_rdy;
        tick();
        if (a === 1'b1) i++;
        guard++;
      end
      if (i < int'(v.len)) chk($sformatf("v%0d_send_timeout", id), 32'(i), 32'(v.len));
    end
    in_vld = 1'b0;
    wait_done();
    chk($sformatf("v%0d_writes", id), 32'(wr_count), 32'(v.exp_writes));
    chk($sformatf("v%0d_accepts", id), 32'(acc_count), 32'(v.len));
    if (v.exp_writes > 0) begin
      chk($sformatf("v%0d_first_x", id), 32'(first_addr), 32'(v.exp_first));
      chk($sformatf("v%0d_last_x", id), 32'(last_addr), 32'(v.exp_last));
    end else begin
      chk($sformatf("v%0d_rdy_cycles", id), 32'(rdy_count), 32'(0));
    end
  endtask

  vec_t vecs [7];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  i;
    int  c;
    logic a;
    for (int k = 0; k < 256; k++) pal_mem[k] = 15'((k * 32'h135) ^ 32'h2A5A);
    pal_mem[5] = 15'h1234;

    vecs[0] = mk(12'd10,   12'd3, 1'b0, 15'h7C00, 15'h03E0, 15'h001F, 15'h0,    4'b0000, 3, 12'd10,   12'd12);
    vecs[1] = mk(12'd20,   12'd1, 1'b0, 15'h0005, 15'h0,    15'h0,    15'h0,    4'b0001, 1, 12'd20,   12'd20);
    vecs[2] = mk(12'd0,    12'd4, 1'b1, 15'h0000, 15'h0007, 15'h0000, 15'h0009, 4'b1111, 2, 12'd1,    12'd3);
    vecs[3] = mk(12'd0,    12'd3, 1'b0, 15'h0000, 15'h0007, 15'h0000, 15'h0,    4'b0111, 3, 12'd0,    12'd2);
    vecs[4] = mk(12'd4094, 12'd4, 1'b0, 15'h1111, 15'h2222, 15'h3333, 15'h4444, 4'b0000, 4, 12'd4094, 12'd1);
    vecs[5] = mk(12'd30,   12'd0, 1'b0, 15'h0001, 15'h0002, 15'h0,    15'h0,    4'b0000, 0, 12'd0,    12'd0);
    vecs[6] = mk(12'd100,  12'd4, 1'b1, 15'h0005, 15'h7FFF, 15'h0003, 15'h0000, 4'b0101, 4, 12'd100,  12'd103);

    rst_n = 1'b0;  en = 1'b0;  flush = 1'b0;  in_vld = 1'b0;
    in_pixdata = 15'h0;  in_paletted = 1'b0;
    cfg_start_x = 12'd0;  cfg_line_len = 12'd0;  cfg_transparency = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) run_line(vecs[v], v);

    // Enable dropped for two cycles mid-line with valid held high.
    clear_stats();
    do_flush(12'd200, 12'd8, 1'b0);
    i = 0;
    c = 0;
    while (i < 8 && c < 40) begin
      en          = !(c == 3 || c == 4);
      in_vld      = 1'b1;
      in_pixdata  = 15'(32'h100 + i);
      in_paletted = 1'b0;
      @(negedge clk);
      a = in_rdy;
      tick();
      if (a === 1'b1) i++;
      c++;
    end
    en = 1'b1;
    in_vld = 1'b0;
    wait_done();
    chk("gap_writes", 32'(wr_count), 32'(8));
    chk("gap_accepts", 32'(acc_count), 32'(8));
    chk("gap_first_x", 32'(first_addr), 32'(200));
    chk("gap_last_x", 32'(last_addr), 32'(207));
    chk("gap_cycles", 32'(c), 32'(10));

    // Reset while stage 2 holds a pixel.
    clear_stats();
    do_flush(12'd50, 12'd5, 1'b0);
    i = 0;
    c = 0;
    while (i < 2 && c < 20) begin
      in_vld      = 1'b1;
      in_pixdata  = 15'(32'h2000 + i);
      in_paletted = 1'b0;
      @(negedge clk);
      a = in_rdy;
      tick();
      if (a === 1'b1) i++;
      c++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_rdy", 32'(in_rdy), 32'(0));
    chk("rst_pal_ren", 32'(pal_ren), 32'(0));
    chk("rst_pal_addr", 32'(pal_addr), 32'(0));
    chk("rst_lbuf_wen", 32'(lbuf_wen), 32'(0));
    chk("rst_lbuf_waddr", 32'(lbuf_waddr), 32'(0));
    chk("rst_lbuf_wdata", 32'(lbuf_wdata), 32'(0));
    chk("rst_line_done", 32'(line_done), 32'(1));
    tick();
    in_vld = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("rst_writes", 32'(wr_count), 32'(2));
    chk("rst_last_x", 32'(last_addr), 32'(51));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
